// File: rtl/alu_iter_exec.sv
// Multi-cycle execute unit. Single-cycle logical/arith/compare/copy ops and
// bit-serial shifts (one position per cycle). Valid/ready on both sides.
module alu_iter_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_aluop,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_illegal,
  output logic             busy
);

  // ALUop encodings shared with the decoder
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLTU   = 4'd6;
  localparam logic [3:0] ALU_SLL    = 4'd7;
  localparam logic [3:0] ALU_SRL    = 4'd8;
  localparam logic [3:0] ALU_SRA    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd10;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   count;
  logic [3:0]       op_q;

  logic [WIDTH-1:0] fast_res;
  logic             fast_ill;
  logic             is_shift;
  logic [WIDTH-1:0] shifted;
  logic [SHW-1:0]   shamt;

  assign shamt     = in_b[SHW-1:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // single-cycle result and shift classification of the incoming request
  always_comb begin
    fast_res = '0;
    fast_ill = 1'b0;
    is_shift = 1'b0;
    case (in_aluop)
      ALU_ADD:    fast_res = in_a + in_b;
      ALU_SUB:    fast_res = in_a - in_b;
      ALU_AND:    fast_res = in_a & in_b;
      ALU_OR:     fast_res = in_a | in_b;
      ALU_XOR:    fast_res = in_a ^ in_b;
      ALU_SLT:    fast_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      ALU_SLTU:   fast_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      ALU_COPY_B: fast_res = in_b;
      ALU_SLL, ALU_SRL, ALU_SRA: is_shift = 1'b1;
      default:    fast_ill = 1'b1;
    endcase
  end

  // one-position step of the latched shift op
  always_comb begin
    shifted = '0;
    case (op_q)
      ALU_SLL: shifted = {acc[WIDTH-2:0], 1'b0};
      ALU_SRL: shifted = {1'b0, acc[WIDTH-1:1]};
      default: shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end

  // control FSM with registered result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      op_q        <= '0;
      out_result  <= '0;
      out_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (is_shift) begin
            acc         <= in_a;
            count       <= shamt;
            op_q        <= in_aluop;
            out_illegal <= 1'b0;
            if (shamt == '0) begin
              out_result <= in_a;
              state      <= DONE;
            end else begin
              state      <= SHIFT;
            end
          end else begin
            out_result  <= fast_res;
            out_illegal <= fast_ill;
            state       <= DONE;
          end
        end
        SHIFT: begin
          acc   <= shifted;
          count <= count - SHW'(1);
          if (count == SHW'(1)) begin
            out_result <= shifted;
            state      <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed bench for alu_iter_exec with an arithmetic reference model and a
// per-cycle compare process.
module tb_alu_iter_exec;
  localparam int W = 32;
  localparam logic [3:0] ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, SLT = 5,
                         SLTU = 6, SLL = 7, SRL = 8, SRA = 9, CPB = 10, XXX = 15;

  logic clk = 0, reset = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, out_illegal, busy;
  logic [3:0] in_aluop = 0;
  logic [W-1:0] in_a = 0, in_b = 0, out_result;

  int checks = 0, failures = 0;

  // expectation state shared by driver and compare process
  logic pending = 0, seen = 0, proto_chk = 1;
  int wait_cnt = 0, exp_lat = 0;
  logic [W-1:0] exp_res = 0;
  logic exp_ill = 0;

  alu_iter_exec #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_illegal(out_illegal),
    .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // reference: what the result, illegal flag and latency must be
  function automatic logic [W+32:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r; logic ill; int lat; int sh;
    sh = int'(b % W); r = 0; ill = 0; lat = 1;
    case (op)
      ADD:  r = a + b;
      SUB:  r = a - b;
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      SLT:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      SLTU: r = (a < b) ? 1 : 0;
      CPB:  r = b;
      SLL:  begin r = a << sh; lat = (sh == 0) ? 1 : sh + 1; end
      SRL:  begin r = a >> sh; lat = (sh == 0) ? 1 : sh + 1; end
      SRA:  begin r = $unsigned($signed(a) >>> sh); lat = (sh == 0) ? 1 : sh + 1; end
      default: ill = 1;
    endcase
    return {ill, lat[31:0], r};
  endfunction

  // per-cycle comparison of DUT outputs against the model expectation
  always @(negedge clk) begin
    if (reset) begin
      chk("busy_vs_ready", busy, !in_ready);
      if (pending && !seen) wait_cnt++;
      if (pending && wait_cnt >= 1 && !seen) chk("ready_low_while_busy", in_ready, 0);
      if (out_valid) begin
        if (!pending) chk("spurious_valid", out_valid, 0);
        else begin
          chk("result", out_result, exp_res);
          chk("illegal", out_illegal, exp_ill);
          if (!seen) chk("latency", wait_cnt, exp_lat);
          seen = 1;
        end
      end
    end
  end

  // requester must hold in_valid and payload until accepted
  logic pv = 0, pr = 0; logic [3:0] pop = 0; logic [W-1:0] pa = 0, pb = 0;
  always @(posedge clk) begin
    if (reset && proto_chk && pv && !pr) begin
      checks++;
      if (!(in_valid && in_aluop == pop && in_a == pa && in_b == pb)) begin
        failures++;
        $display("FAIL protocol_hold in_valid=%b", in_valid);
      end
    end
    pv = in_valid; pr = in_ready; pop = in_aluop; pa = in_a; pb = in_b;
  end

  // issue one request; model outputs checked against hand literals
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] lres, input logic lill, input int llat);
    logic [W+32:0] m; int n;
    m = model(op, a, b);
    chk("model_res", m[W-1:0], lres);
    chk("model_ill", {31'b0, m[W+32]}, {31'b0, lill});
    chk("model_lat", m[W+31:W], llat);
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) chk("ready_timeout", in_ready, 1);
    #1;
    exp_res = m[W-1:0]; exp_ill = m[W+32]; exp_lat = int'(m[W+31:W]);
    wait_cnt = 0; seen = 0; pending = 1;
    in_valid = 1; in_aluop = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 0; in_a = $urandom; in_b = $urandom; in_aluop = 4'($urandom);
  endtask

  // wait for the result, check it against literal, and complete handshake
  task automatic finish_op(input logic [W-1:0] lres);
    int n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < W + 8);
    chk("valid_seen", out_valid, 1);
    chk("lit_result", out_result, lres);
    out_ready = 1;
    @(posedge clk); #1;
    pending = 0;
    chk("idle_after_ack", {out_valid, in_ready}, 2'b01);
  endtask

  task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] lres, input logic lill, input int llat);
    issue(op, a, b, lres, lill, llat);
    finish_op(lres);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", out_result, 0);
    chk("rst_illegal", out_illegal, 0);
    @(negedge clk); reset = 1;

    run(ADD, 32'hFFFF_FFFF, 1, 32'h0, 0, 1);
    run(SUB, 0, 1, 32'hFFFF_FFFF, 0, 1);
    run(SLT, 32'h8000_0000, 1, 1, 0, 1);
    run(SLTU, 32'h8000_0000, 1, 0, 0, 1);
    run(CPB, 32'h1111_1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1);
    run(AND_, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 0, 1);
    run(OR_, 32'hFF00_0000, 32'h0000_00FF, 32'hFF00_00FF, 0, 1);
    run(SRA, 32'h8000_00F0, 32'h0000_0104, 32'hF800_000F, 0, 5);
    run(SLL, 1, 31, 32'h8000_0000, 0, 32);
    run(SRL, 32'h1234_5678, 0, 32'h1234_5678, 0, 1);
    run(SRL, 32'h8000_0000, 3, 32'h1000_0000, 0, 4);
    run(4'd12, 32'h5, 32'h6, 0, 1, 1);

    // backpressure with stray in_valid pulses during the stall
    out_ready = 0;
    issue(XOR_, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 0, 1);
    proto_chk = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_ready", in_ready, 0);
      in_valid = i[0]; in_aluop = ADD; in_a = i; in_b = 7;
    end
    in_valid = 0;
    @(posedge clk); #1;
    proto_chk = 1;
    finish_op(32'h0F0F_F0F0);
    repeat (3) @(negedge clk);
    chk("no_stray_accept", out_valid, 0);

    // reset in the middle of a long shift
    issue(SRL, 32'hFFFF_FFFF, 20, 32'h0000_0FFF, 0, 21);
    repeat (5) @(posedge clk);
    #1; reset = 0; #1;
    pending = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    @(negedge clk); reset = 1;
    repeat (25) @(negedge clk);
    chk("abort_no_result", out_valid, 0);
    run(XXX, 32'h1234, 32'h5678, 0, 1, 1);
    run(ADD, 32'h7FFF_FFFF, 1, 32'h8000_0000, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
